// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the CPU and the HI/LO multiply/divide unit.
// The CPU drives the requests (master); the unit returns HI/LO and status (slave).
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rd_hilo;
  logic              wr_hi;
  logic              wr_lo;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              stall;
  logic              done;
  logic              div0;

  modport master (
    output start, op, rs_data, rt_data, rd_hilo, wr_hi, wr_lo, wr_data,
    input  hi, lo, busy, stall, done, div0
  );

  modport slave (
    input  start, op, rs_data, rt_data, rd_hilo, wr_hi, wr_lo, wr_data,
    output hi, lo, busy, stall, done, div0
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
//
// state | meaning
// IDLE  | waiting for start; services mthi/mtlo
// MUL   | shift-add iterations on magnitudes
// DIV   | restoring shift-subtract iterations on magnitudes
// FIX   | sign correction / divide-by-zero result, write HI/LO, pulse done
module hilo_muldiv_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input logic              clock,
  input logic              reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]   opa;      // |rs|, kept for the divide-by-zero result
  logic [DATA_W-1:0]   opb;      // |rt|
  logic                neg_q;    // product / quotient is negative
  logic                neg_r;    // remainder is negative (dividend sign)
  logic                dz;
  logic                is_div;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                busy_q;
  logic                done_q;
  logic                div0_q;

  logic                is_signed;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   rs_orig;

  assign is_signed = ~bus.op[0];
  assign rs_mag    = (is_signed && bus.rs_data[DATA_W-1]) ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = (is_signed && bus.rt_data[DATA_W-1]) ? -bus.rt_data : bus.rt_data;

  // Datapath for one iteration and for the final sign correction.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opa} : '0);
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_fix   = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    rs_orig   = neg_r ? -opa : opa;
  end

  // Sequencer, operand capture, iteration and HI/LO ownership.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
      hi_q   <= HILO_RST;
      lo_q   <= HILO_RST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            div0_q <= 1'b0;
            cnt    <= '0;
            opa    <= rs_mag;
            opb    <= rt_mag;
            neg_q  <= is_signed & (bus.rs_data[DATA_W-1] ^ bus.rt_data[DATA_W-1]);
            neg_r  <= is_signed & bus.rs_data[DATA_W-1];
            dz     <= bus.op[1] & (bus.rt_data == '0);
            is_div <= bus.op[1];
            acc    <= {{DATA_W{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
            state  <= bus.op[1] ? DIV : MUL;
          end else begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[DATA_W-1:1]};
          if (cnt == CNT_LAST) state <= FIX;
          else                 cnt   <= cnt + 1'b1;
        end
        DIV: begin
          if (!div_diff[DATA_W]) acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
          else                   acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
          if (cnt == CNT_LAST) state <= FIX;
          else                 cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            if (dz) begin
              hi_q   <= rs_orig;
              lo_q   <= '1;
              div0_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.div0  = div0_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);

endmodule
